mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Initiator side of the data-memory port: accepts one load/store request from the CPU MEM stage over a valid/ready handshake.
- Drives the async-read / sync-write byte-addressed data memory: read/write strobes, address, write data, funct3.
- Captures load data and returns a registered response with an error flag.
- Sits between the execute/MEM pipeline stage and the data memory; one outstanding access at a time.

Parameters:
- MEM_SIZE, 256, memory depth in 32-bit words; valid byte range is 0 .. MEM_SIZE*4-1.
- ADDR_W, 32, request/memory address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  unit can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  32  store data, right-aligned; passed unmodified.
- req_f3_i  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU or SB/SH/SW).
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  consumer takes response.
- rsp_rdata_o  out  32  load result, already extended by memory; 0 for stores and errors.
- rsp_err_o  out  1  access faulted, no memory effect.
- rsp_cause_o  out  2  01 out-of-range, 10 misaligned, 11 illegal funct3, 00 none.
- mem_re_o  out  1  memory read enable.
- mem_wr_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory byte address.
- mem_wdata_o  out  32  memory write data.
- mem_f3_o  out  3  memory funct3.
- mem_data_i  in  32  memory combinational read data.

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (async) forces IDLE. All outputs reset to 0 except req_ready_o=1.
- IDLE:
  - req_ready_o=1.
  - On posedge with req_valid_i && req_ready_o: latch we/addr/wdata/f3 and run the checker.
  - No error -> ACCESS. Error -> RESP with rsp_err_o=1, cause set, no strobe ever raised.
- ACCESS (exactly one cycle):
  - mem_re_o = !we, mem_wr_o = we.
  - mem_addr_o, mem_f3_o, mem_wdata_o come from the latched request.
  - Load: mem_data_i is registered into rsp_rdata_o at the closing edge.
  - Store: memory commits at that same edge; rsp_rdata_o = 0.
  - -> RESP.
- RESP:
  - rsp_valid_o=1; response fields held stable until rsp_valid_o && rsp_ready_i at a posedge -> IDLE.
  - req_ready_o=0. No back-to-back accept in the same cycle as response retire.
- Latency: accept edge E0, strobe during cycle E0..E1, rsp_valid_o high from E1. Error responses are valid from E0.
- Strobes are 0 in IDLE and RESP. mem_addr_o/mem_f3_o/mem_wdata_o hold the last latched values.
- Checker:
  - Access size: 1 (f3[1:0]=00), 2 (01), 4 (10).
  - Out-of-range when addr + size - 1 > MEM_SIZE*4-1; compute with ADDR_W+1 bits so 0xFFFFFFFF does not wrap.
  - Illegal funct3: loads 011/110/111; stores >= 011.
  - Priority: illegal funct3 > out-of-range > misaligned.
- Reset mid-ACCESS drops strobes immediately. The memory gates writes on rst, so no partial store.
- Reset mid-RESP discards the response.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined: a halfword access with addr[0]!=0, or a word access with addr[1:0]!=0, faults with cause 10 and no strobe.
- Undefined: misaligned accesses proceed to ACCESS, since the memory handles byte-granular addresses natively; cause 10 is never produced.

Decomposition:
- Shared defines file (alongside the existing funct3 and bus-width macros) gains:
  - State encodings MAU_IDLE/MAU_ACCESS/MAU_RESP.
  - Cause codes MAU_ERR_NONE/RANGE/MISALIGN/ILLF3.
- Reuse the existing F3_* load/store macros and DataBus/Funct3Bus widths.
- One natural combinational sub-module, mem_access_check: inputs we/addr/f3, outputs err and cause. Honours MEM_MISALIGN_TRAP_EN and MEM_SIZE.

Test Plan:
- SW 0xDEADBEEF to 0x10, then LW 0x10 -> mem_wr_o pulses for exactly one cycle; load rsp_rdata_o=0xDEADBEEF, rsp_err_o=0, rsp_valid_o one cycle after accept.
- SB 0x80 at 0x20, then LB 0x20 and LBU 0x20 -> rdata 0xFFFFFF80 and 0x00000080.
- LW at 0x3FE with MEM_SIZE=256 -> err=1, cause=01, mem_re_o never asserted, rsp_valid_o at the accept edge.
- LH at 0x11: with MEM_MISALIGN_TRAP_EN -> err, cause=10, no strobe; without -> normal load of bytes 0x11/0x12.
- Store with f3=011 -> err, cause=11. Hold rsp_ready_i=0 for 5 cycles -> rsp fields stable, req_ready_o=0 throughout.
- Assert rst during ACCESS of SW 0x12345678 to 0x30 -> strobes drop immediately, state IDLE, subsequent LW 0x30 returns the old value.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: bus widths, RISC-V
// load/store funct3 encodings, FSM state encoding and fault cause codes.
package mem_access_unit_pkg;

    localparam int DataBus   = 32;
    localparam int Funct3Bus = 3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        MAU_IDLE   = 2'd0,
        MAU_ACCESS = 2'd1,
        MAU_RESP   = 2'd2
    } mauState_t;

    localparam logic [1:0] MAU_ERR_NONE     = 2'b00;
    localparam logic [1:0] MAU_ERR_RANGE    = 2'b01;
    localparam logic [1:0] MAU_ERR_MISALIGN = 2'b10;
    localparam logic [1:0] MAU_ERR_ILLF3    = 2'b11;

    // Number of bytes touched beyond the first one, from funct3[1:0].
    function automatic logic [2:0] accessSizeMinus1(input logic [1:0] sizeCode);
        case (sizeCode)
            2'b00:   accessSizeMinus1 = 3'd0;
            2'b01:   accessSizeMinus1 = 3'd1;
            default: accessSizeMinus1 = 3'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_check.sv
// Combinational request checker: classifies a load/store as illegal funct3,
// out of range or misaligned. Misalignment trapping only exists when the
// build defines MEM_MISALIGN_TRAP_EN; otherwise the byte-granular memory
// handles unaligned addresses and no misalignment fault is raised.
import mem_access_unit_pkg::*;

module mem_access_check #(
    parameter int MEM_SIZE = 256,
    parameter int ADDR_W   = 32
) (
    input  logic                 we_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [Funct3Bus-1:0] f3_i,
    output logic                 err_o,
    output logic [1:0]           cause_o
);

    localparam logic [ADDR_W:0] LAST_BYTE = (ADDR_W+1)'(MEM_SIZE*4-1);

    logic              illegalF3;
    logic              outOfRange;
    logic              misaligned;
    logic [ADDR_W:0]   lastByte;

    // Evaluate every fault class, then pick the highest-priority one; the
    // last-byte sum carries one extra bit so addresses near the top never wrap.
    always_comb begin
        if (we_i) begin
            illegalF3 = !(f3_i inside {F3_SB, F3_SH, F3_SW});
        end else begin
            illegalF3 = !(f3_i inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        end
        lastByte   = {1'b0, addr_i} + (ADDR_W+1)'(accessSizeMinus1(f3_i[1:0]));
        outOfRange = lastByte > LAST_BYTE;
`ifdef MEM_MISALIGN_TRAP_EN
        misaligned = ((f3_i[1:0] == 2'b01) && addr_i[0]) ||
                     ((f3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
        err_o   = illegalF3 || outOfRange || misaligned;
        cause_o = MAU_ERR_NONE;
        if (illegalF3) begin
            cause_o = MAU_ERR_ILLF3;
        end else if (outOfRange) begin
            cause_o = MAU_ERR_RANGE;
        end else if (misaligned) begin
            cause_o = MAU_ERR_MISALIGN;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the data-memory port. Accepts one load/store at a time,
// strobes the async-read/sync-write memory for exactly one cycle and returns
// a registered response. Faulting requests skip the memory entirely.
// Optional build macro: MEM_MISALIGN_TRAP_EN (see mem_access_check).
import mem_access_unit_pkg::*;

module mem_access_unit #(
    parameter int MEM_SIZE = 256,
    parameter int ADDR_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [ADDR_W-1:0]    req_addr_i,
    input  logic [DataBus-1:0]   req_wdata_i,
    input  logic [Funct3Bus-1:0] req_f3_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataBus-1:0]   rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic [1:0]           rsp_cause_o,
    output logic                 mem_re_o,
    output logic                 mem_wr_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [DataBus-1:0]   mem_wdata_o,
    output logic [Funct3Bus-1:0] mem_f3_o,
    input  logic [DataBus-1:0]   mem_data_i
);

    mauState_t              state_q;
    logic                   reqReady_q;
    logic                   rspValid_q;
    logic [DataBus-1:0]     rspData_q;
    logic                   rspErr_q;
    logic [1:0]             rspCause_q;
    logic                   memRe_q;
    logic                   memWr_q;
    logic [ADDR_W-1:0]      memAddr_q;
    logic [DataBus-1:0]     memWdata_q;
    logic [Funct3Bus-1:0]   memF3_q;
    logic                   chkErr;
    logic [1:0]             chkCause;

    mem_access_check #(
        .MEM_SIZE (MEM_SIZE),
        .ADDR_W   (ADDR_W)
    ) u_check (
        .we_i    (req_we_i),
        .addr_i  (req_addr_i),
        .f3_i    (req_f3_i),
        .err_o   (chkErr),
        .cause_o (chkCause)
    );

    // Request/access/response sequencer; every output is a register so the
    // memory strobes and response fields are glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= MAU_IDLE;
            reqReady_q <= 1'b1;
            rspValid_q <= 1'b0;
            rspData_q  <= '0;
            rspErr_q   <= 1'b0;
            rspCause_q <= MAU_ERR_NONE;
            memRe_q    <= 1'b0;
            memWr_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            memF3_q    <= '0;
        end else begin
            case (state_q)
                MAU_IDLE: begin
                    if (req_valid_i && reqReady_q) begin
                        memAddr_q  <= req_addr_i;
                        memWdata_q <= req_wdata_i;
                        memF3_q    <= req_f3_i;
                        reqReady_q <= 1'b0;
                        if (chkErr) begin
                            rspValid_q <= 1'b1;
                            rspErr_q   <= 1'b1;
                            rspCause_q <= chkCause;
                            rspData_q  <= '0;
                            state_q    <= MAU_RESP;
                        end else begin
                            memRe_q <= !req_we_i;
                            memWr_q <= req_we_i;
                            state_q <= MAU_ACCESS;
                        end
                    end
                end
                MAU_ACCESS: begin
                    memRe_q    <= 1'b0;
                    memWr_q    <= 1'b0;
                    rspData_q  <= memWr_q ? '0 : mem_data_i;
                    rspErr_q   <= 1'b0;
                    rspCause_q <= MAU_ERR_NONE;
                    rspValid_q <= 1'b1;
                    state_q    <= MAU_RESP;
                end
                MAU_RESP: begin
                    if (rsp_ready_i) begin
                        rspValid_q <= 1'b0;
                        reqReady_q <= 1'b1;
                        state_q    <= MAU_IDLE;
                    end
                end
                default: begin
                    state_q <= MAU_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = reqReady_q;
    assign rsp_valid_o = rspValid_q;
    assign rsp_rdata_o = rspData_q;
    assign rsp_err_o   = rspErr_q;
    assign rsp_cause_o = rspCause_q;
    assign mem_re_o    = memRe_q;
    assign mem_wr_o    = memWr_q;
    assign mem_addr_o  = memAddr_q;
    assign mem_wdata_o = memWdata_q;
    assign mem_f3_o    = memF3_q;

endmodule
